// File: rtl/fbgen.sv
// Feedback-pulse generator: emits a commanded number of evenly spread pulses per window
// using a DDA phase accumulator feeding a pulse-shaping FSM.
module fbgen #(
   parameter int unsigned CLK_FREQ    = 125000000,
   parameter real         EDGE_PERIOD = 0.5,
   parameter int unsigned PULSE_CYC   = 4
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        en,
   input  logic [15:0] edge_target,
   output logic        fbp_out,
   output logic [15:0] edge_cnt_out,
   output logic        sat,
   output logic        ovf
);

   localparam int unsigned N         = int'($rtoi(real'(CLK_FREQ) * EDGE_PERIOD + 0.5));
   localparam int unsigned MAX_EDGES = N / (2 * PULSE_CYC);
   localparam int unsigned PW        = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   localparam logic [25:0]    WIN_MAX  = 26'(N - 1);
   localparam logic [26:0]    N27      = 27'(N);
   localparam logic [31:0]    MAX_E32  = 32'(MAX_EDGES);
   localparam logic [15:0]    MAX_E16  = (MAX_EDGES > 65535) ? 16'hFFFF : 16'(MAX_EDGES);
   localparam logic [PW-1:0]  PW_LOAD  = PW'(PULSE_CYC - 1);

   typedef enum logic [1:0] {StIdle, StHigh, StGuard} state_e;

   state_e        state_q, state_d;
   logic [25:0]   win_q, win_d;
   logic [26:0]   acc_q, acc_d;
   logic [15:0]   target_q, target_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   edge_cnt_q, edge_cnt_d;
   logic [PW-1:0] pw_q, pw_d;
   logic          pending_q, pending_d;
   logic          sat_q, sat_d;
   logic          ovf_q, ovf_d;
   logic          fbp_q, fbp_d;

   logic        boundary;
   logic        req;
   logic        pend;
   logic        start;
   logic [26:0] s;
   logic [15:0] cnt_inc;

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      acc_d      = acc_q;
      target_d   = target_q;
      cnt_d      = cnt_q;
      edge_cnt_d = edge_cnt_q;
      pw_d       = pw_q;
      pending_d  = pending_q;
      sat_d      = sat_q;
      ovf_d      = ovf_q;
      req        = 1'b0;
      start      = 1'b0;
      pend       = pending_q & en;

      boundary = (win_q == WIN_MAX);
      win_d    = boundary ? 26'd0 : win_q + 26'd1;

      s = acc_q + {11'd0, target_q};
      if (en) begin
         if (s >= N27) begin
            acc_d = s - N27;
            req   = 1'b1;
         end else begin
            acc_d = s;
         end
      end else begin
         acc_d = '0;
      end

      unique case (state_q)
         StIdle: begin
            if (req || pend) begin
               state_d   = StHigh;
               pw_d      = PW_LOAD;
               start     = 1'b1;
               pending_d = req & pend;
            end
         end
         StHigh: begin
            if (pw_q == '0) begin
               state_d = StGuard;
               pw_d    = PW_LOAD;
            end else begin
               pw_d = pw_q - 1'b1;
            end
            if (req) begin
               if (pend) ovf_d = 1'b1;
               else      pending_d = 1'b1;
            end
         end
         StGuard: begin
            // A request landing on the last guard cycle starts the next pulse with no idle gap.
            if (pw_q == '0) begin
               if (req || pend) begin
                  state_d   = StHigh;
                  pw_d      = PW_LOAD;
                  start     = 1'b1;
                  pending_d = req & pend;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               pw_d = pw_q - 1'b1;
               if (req) begin
                  if (pend) ovf_d = 1'b1;
                  else      pending_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (!en) pending_d = 1'b0;

      cnt_inc = (start && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
      if (boundary) begin
         edge_cnt_d = cnt_inc;
         cnt_d      = '0;
         target_d   = ({16'd0, edge_target} > MAX_E32) ? MAX_E16 : edge_target;
         sat_d      = ({16'd0, edge_target} > MAX_E32);
      end else begin
         cnt_d = cnt_inc;
      end

      fbp_d = (state_d == StHigh);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= StIdle;
         win_q      <= '0;
         acc_q      <= '0;
         target_q   <= '0;
         cnt_q      <= '0;
         edge_cnt_q <= '0;
         pw_q       <= '0;
         pending_q  <= 1'b0;
         sat_q      <= 1'b0;
         ovf_q      <= 1'b0;
         fbp_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         acc_q      <= acc_d;
         target_q   <= target_d;
         cnt_q      <= cnt_d;
         edge_cnt_q <= edge_cnt_d;
         pw_q       <= pw_d;
         pending_q  <= pending_d;
         sat_q      <= sat_d;
         ovf_q      <= ovf_d;
         fbp_q      <= fbp_d;
      end
   end

   assign fbp_out      = fbp_q;
   assign edge_cnt_out = edge_cnt_q;
   assign sat          = sat_q;
   assign ovf          = ovf_q;

endmodule

// File: tb/tb_fbgen.sv
// Scoreboard bench for fbgen: a window-level reference model queues expected pulse times and
// per-window reports; a monitor pops and compares them as the DUT produces edges and reports.
module tb_fbgen;

   localparam int unsigned N    = 100;
   localparam int unsigned PW   = 4;
   localparam int unsigned MAXE = 12;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        en = 1'b0;
   logic [15:0] edge_target = '0;
   logic        fbp_out;
   logic [15:0] edge_cnt_out;
   logic        sat;
   logic        ovf;

   fbgen #(
      .CLK_FREQ   (1000),
      .EDGE_PERIOD(0.1),
      .PULSE_CYC  (PW)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .en          (en),
      .edge_target (edge_target),
      .fbp_out     (fbp_out),
      .edge_cnt_out(edge_cnt_out),
      .sat         (sat),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cnt;
      bit          sat;
   } rep_t;

   int          tests = 0;
   int          fails = 0;
   int unsigned tick = 0;
   int unsigned exp_rise_q[$];
   rep_t        rep_q[$];
   bit          rst_seen = 1'b0;
   bit          rep_due = 1'b0;

   int unsigned m_win = 0;
   int unsigned m_acc = 0;
   int unsigned m_tgt = 0;
   int unsigned m_edges = 0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, act, exp, tick);
      end
   endtask

   // Reference model: target latched per window, phase wraps modulo N give the edge instants.
   initial begin
      forever begin
         @(posedge clk);
         tick++;
         rep_due  = 1'b0;
         rst_seen = !n_rst;
         if (!n_rst) begin
            m_win = 0;
            m_acc = 0;
            m_tgt = 0;
            m_edges = 0;
            exp_rise_q.delete();
            rep_q.delete();
         end else begin
            if (en) begin
               if (m_acc + m_tgt >= N) begin
                  exp_rise_q.push_back(tick);
                  m_edges++;
               end
               m_acc = (m_acc + m_tgt) % N;
            end else begin
               m_acc = 0;
            end
            if (m_win == N - 1) begin
               rep_q.push_back('{cnt: m_edges, sat: (edge_target > MAXE)});
               rep_due = 1'b1;
               m_tgt   = (edge_target > MAXE) ? MAXE : int'(edge_target);
               m_edges = 0;
            end
            m_win = (m_win + 1) % N;
         end
      end
   end

   // Monitor: compares every DUT edge and window report against the queued expectations.
   initial begin
      bit          prev;
      int unsigned rise_t;
      rep_t        r;
      prev   = 1'b0;
      rise_t = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_seen) begin
            check("rst_fbp", fbp_out, 0);
            check("rst_edge_cnt", edge_cnt_out, 0);
            check("rst_sat", sat, 0);
            check("rst_ovf", ovf, 0);
            prev = 1'b0;
         end else begin
            if (fbp_out && !prev) begin
               rise_t = tick;
               if (exp_rise_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_edge: got edge at tick %0d, expected none", tick);
               end else begin
                  check("edge_time", tick, exp_rise_q.pop_front());
               end
            end
            if (!fbp_out && prev) check("pulse_width", tick - rise_t, PW);
            if (rep_due) begin
               if (rep_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL report_missing: got report, expected none queued");
               end else begin
                  r = rep_q.pop_front();
                  check("edge_cnt_out", edge_cnt_out, r.cnt);
                  check("sat", sat, r.sat);
                  check("ovf", ovf, 0);
               end
            end
            prev = fbp_out;
         end
      end
   end

   task automatic wait_rise();
      bit was;
      was = fbp_out;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (fbp_out && !was) return;
         was = fbp_out;
      end
      tests++;
      fails++;
      $display("FAIL wait_rise: got no rising edge in 400 cycles, expected one");
   endtask

   initial begin
      int tl[4];
      tl = '{7, 7, 50, 3};
      repeat (5) @(negedge clk);
      n_rst       = 1'b1;
      en          = 1'b1;
      edge_target = 16'd5;
      repeat (3 * N) @(negedge clk);

      // Constant, saturating and random targets, each applied at a random point mid-window.
      for (int i = 0; i < 12; i++) begin
         int unsigned t;
         int unsigned off;
         t   = (i < 4) ? tl[i] : $urandom_range(0, 30);
         off = $urandom_range(1, N - 1);
         repeat (off) @(negedge clk);
         edge_target = 16'(t);
         repeat (2 * N - off) @(negedge clk);
      end

      edge_target = 16'd4;
      repeat (2 * N) @(negedge clk);
      while (m_win != 50) @(negedge clk);
      edge_target = 16'd9;
      repeat (2 * N) @(negedge clk);

      // Drop enable during the second high cycle of a pulse.
      wait_rise();
      @(negedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (150) @(negedge clk);
      en = 1'b1;
      repeat (2 * N) @(negedge clk);

      // Reset in the middle of a pulse at the maximum rate.
      edge_target = 16'd50;
      repeat (2 * N) @(negedge clk);
      wait_rise();
      @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      repeat (3 * N) @(negedge clk);

      repeat (10) @(negedge clk);
      check("edges_outstanding", exp_rise_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
